// File: rtl/counters_pkg.sv
// Shared definitions for the counter/timer building blocks.
package counters_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles into one tick every PRESCALE cycles.
// With PRESCALE=1 every enabled cycle is a tick and no counter exists.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clr};
            assign tick = en;
        end else begin : g_count
            localparam int CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            assign tick = en && (cnt_q == LAST);

            // NOTE: always_comb assigns every output a default first so no latch is inferred.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en) begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                end
            end

            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counting interval timer with prescaler, one-shot or
// auto-reload operation and a registered terminal-count pulse.
module down_counter_timer
    import counters_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             pre_en, pre_clr, tick;
    logic             go;

    // stop outranks start in every state, and load outranks both.
    assign go     = start && !stop && !load;
    assign pre_en = (state_q == RUN) && !load && !stop;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        pre_clr  = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            pre_clr  = 1'b1;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go && count_q != '0) begin
                        pre_clr = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = HOLD;
                    end else if (tick) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (go) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (go && reload_q != '0) begin
                        count_d = reload_q;
                        pre_clr = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: PRESCALE=1 and PRESCALE=4 instances share
// stimulus and are compared every cycle against a period-level timer model.
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst_n, load, start, stop, auto_reload;
    logic [7:0] load_val;
    logic [7:0] count0, count1;
    logic       busy0, busy1, done0, done1, tc0, tc1;

    int checks   = 0;
    int failures = 0;

    // Model: remaining count, stored period, cycles elapsed in current tick.
    int m_cnt [2];
    int m_rel [2];
    int m_ph  [2];
    bit m_run [2];
    bit m_hold[2];
    bit m_done[2];
    bit m_tc  [2];

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(8), .PRESCALE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .count(count0), .busy(busy0), .done(done0), .tc(tc0)
    );

    down_counter_timer #(.WIDTH(8), .PRESCALE(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .count(count1), .busy(busy1), .done(done1), .tc(tc1)
    );

    task automatic check(string tag, logic [31:0] obs, int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(int i);
        int period = (i == 0) ? 1 : 4;
        m_tc[i] = 1'b0;
        if (!rst_n) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_ph[i] = 0;
            m_run[i] = 0; m_hold[i] = 0; m_done[i] = 0;
        end else if (load) begin
            m_cnt[i] = int'(load_val); m_rel[i] = int'(load_val); m_ph[i] = 0;
            m_run[i] = 0; m_hold[i] = 0; m_done[i] = 0;
        end else if (m_run[i]) begin
            if (stop) begin
                m_run[i] = 0; m_hold[i] = 1;
            end else begin
                m_ph[i]++;
                if (m_ph[i] == period) begin
                    m_ph[i] = 0;
                    if (m_cnt[i] > 1) begin
                        m_cnt[i]--;
                    end else begin
                        m_tc[i] = 1;
                        if (auto_reload) begin
                            m_cnt[i] = m_rel[i];
                        end else begin
                            m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 1;
                        end
                    end
                end
            end
        end else if (m_hold[i]) begin
            if (start && !stop) begin
                m_hold[i] = 0; m_run[i] = 1;
            end
        end else if (m_done[i]) begin
            if (start && !stop && m_rel[i] != 0) begin
                m_cnt[i] = m_rel[i]; m_ph[i] = 0; m_done[i] = 0; m_run[i] = 1;
            end
        end else if (start && !stop && m_cnt[i] != 0) begin
            m_run[i] = 1; m_ph[i] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("count_p1", {24'b0, count0}, m_cnt[0]);
        check("busy_p1",  {31'b0, busy0},  int'(m_run[0]));
        check("done_p1",  {31'b0, done0},  int'(m_done[0]));
        check("tc_p1",    {31'b0, tc0},    int'(m_tc[0]));
        check("count_p4", {24'b0, count1}, m_cnt[1]);
        check("busy_p4",  {31'b0, busy1},  int'(m_run[1]));
        check("done_p4",  {31'b0, done1},  int'(m_done[1]));
        check("tc_p4",    {31'b0, tc1},    int'(m_tc[1]));
    endtask

    task automatic step(bit r, bit ld, logic [7:0] v, bit st, bit sp, bit ar);
        rst_n = r; load = ld; load_val = v; start = st; stop = sp; auto_reload = ar;
        cycle();
    endtask

    task automatic idle(int n, bit ar);
        for (int k = 0; k < n; k++) step(1, 0, 8'd0, 0, 0, ar);
    endtask

    initial begin
        rst_n = 0; load = 0; load_val = 0; start = 0; stop = 0; auto_reload = 0;

        step(0, 0, 8'd0, 0, 0, 0);
        step(0, 1, 8'd9, 1, 0, 0);
        check("rst_count", {24'b0, count0}, 0);
        check("rst_busy",  {31'b0, busy0}, 0);

        // start with a zero count is ignored
        step(1, 0, 8'd0, 1, 0, 0);
        check("zero_start_busy", {31'b0, busy0}, 0);

        // one-shot, load 3
        step(1, 1, 8'd3, 0, 0, 0);
        check("os_load", {24'b0, count0}, 3);
        step(1, 0, 8'd0, 1, 0, 0);
        check("os_e0", {24'b0, count0}, 3);
        idle(1, 0);
        check("os_e1", {24'b0, count0}, 2);
        idle(1, 0);
        check("os_e2", {24'b0, count0}, 1);
        idle(1, 0);
        check("os_e3", {24'b0, count0}, 0);
        check("os_tc", {31'b0, tc0}, 1);
        check("os_done", {31'b0, done0}, 1);
        idle(14, 0);
        check("os_hold0", {24'b0, count0}, 0);
        // restart from DONE reloads the stored period
        step(1, 0, 8'd0, 1, 0, 0);
        check("done_restart", {24'b0, count0}, 3);
        idle(14, 0);

        // auto-reload, load 2
        step(1, 1, 8'd2, 0, 0, 1);
        step(1, 0, 8'd0, 1, 0, 1);
        idle(20, 1);

        // pause/resume, load 5
        step(1, 1, 8'd5, 0, 0, 0);
        step(1, 0, 8'd0, 1, 0, 0);
        idle(2, 0);
        step(1, 0, 8'd0, 1, 1, 0);
        idle(3, 0);
        check("hold_count", {24'b0, count0}, 3);
        check("hold_busy", {31'b0, busy0}, 0);
        step(1, 0, 8'd0, 1, 0, 0);
        idle(24, 0);

        // load during RUN
        step(1, 1, 8'd5, 0, 0, 0);
        step(1, 0, 8'd0, 1, 0, 0);
        idle(3, 0);
        step(1, 1, 8'd7, 0, 0, 0);
        check("ldrun_count", {24'b0, count0}, 7);
        check("ldrun_busy", {31'b0, busy0}, 0);
        check("ldrun_tc", {31'b0, tc0}, 0);
        step(1, 0, 8'd0, 1, 0, 0);
        idle(30, 0);

        // PRESCALE=4 timing on dut1
        step(1, 1, 8'd2, 0, 0, 0);
        step(1, 0, 8'd0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            idle(1, 0);
            if (k == 3) check("p4_e3", {24'b0, count1}, 2);
            if (k == 4) check("p4_e4", {24'b0, count1}, 1);
            if (k == 7) check("p4_e7_tc", {31'b0, tc1}, 0);
        end
        check("p4_e8_tc", {31'b0, tc1}, 1);
        check("p4_e8_done", {31'b0, done1}, 1);
        idle(2, 0);

        // start+stop together in IDLE, then reset mid-RUN
        step(1, 1, 8'd6, 0, 0, 0);
        step(1, 0, 8'd0, 1, 1, 0);
        check("ss_idle_busy", {31'b0, busy0}, 0);
        step(1, 0, 8'd0, 1, 0, 0);
        idle(2, 0);
        step(0, 0, 8'd0, 0, 0, 0);
        check("midrst_count", {24'b0, count0}, 0);
        check("midrst_busy", {31'b0, busy0}, 0);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            int sel;
            logic [7:0] v;
            sel = int'($urandom_range(0, 9));
            v = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(1, 6));
            step($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 5, v,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
